cache_dm_wb: RTL and testbench

//  Direct-mapped, write-back, write-allocate cache between the CPU word port and

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_line_array.sv | 55 +++++
 rtl/cache_dm_wb.sv | 152 +++++++++++++++
 tb/tb_cache_dm_wb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache.
// Address split: offset = [4:0], index = [4+S_INDEX:5], tag = [31:5+S_INDEX].
// The field helpers take the index width as an argument and return
// right-justified 32-bit fields. Callers cast the result to the field width.
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int s_index);
    return addr >> (OFFSET_W + s_index);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int s_index);
    return (addr >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [2:0] get_word(input logic [31:0] addr);
    return addr[4:2];
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// Storage for the cache lines: data, tag, valid and dirty, one entry per index.
// A single index addresses both the read and the write side. Each field has
// its own write enable, so the controller can update fields independently.
// Only valid and dirty are reset. Data and tag hold garbage until the first fill.
// Ports: clk, reset_n (async low); index; {data,tag,valid,dirty}_we/_in write
//   side; {data,tag,valid,dirty}_out combinational read of the entry at index.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int TAG_W   = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [S_INDEX-1:0] index,
  input  logic               data_we,
  input  logic [LINE_W-1:0]  data_in,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               valid_we,
  input  logic               valid_in,
  input  logic               dirty_we,
  input  logic               dirty_in,
  output logic [LINE_W-1:0]  data_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               valid_out,
  output logic               dirty_out
);
  localparam int LINES = 1 << S_INDEX;

  logic [LINE_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid_arr;
  logic [LINES-1:0]  dirty_arr;

  always_ff @(posedge clk) begin
    if (data_we) data_arr[index] <= data_in;
    if (tag_we)  tag_arr[index]  <= tag_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      if (valid_we) valid_arr[index] <= valid_in;
      if (dirty_we) dirty_arr[index] <= dirty_in;
    end
  end

  assign data_out  = data_arr[index];
  assign tag_out   = tag_arr[index];
  assign valid_out = valid_arr[index];
  assign dirty_out = dirty_arr[index];
endmodule

// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate cache. It sits between the CPU
// word port and the cacheline adaptor.
// Hits complete one cycle after the request. A miss first writes back a dirty
// victim, if there is one. It then fills the line and returns to IDLE, where
// the held request is looked up again and now hits.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   mem_address/read/write/byte_en/wdata  CPU request (held until mem_resp)
//   mem_rdata, mem_resp   CPU response (one-cycle pulse)
//   pmem_address/read/write/wdata         line request to adaptor
//   pmem_rdata, pmem_resp                 line response from adaptor
module cache_dm_wb
  import cache_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int TAG_W = ADDR_W - OFFSET_W - S_INDEX;

  state_t state, state_n;

  logic [TAG_W-1:0]   tag;
  logic [S_INDEX-1:0] idx;
  logic [2:0]         word;
  logic               unused;

  assign tag    = TAG_W'(get_tag(mem_address, S_INDEX));
  assign idx    = S_INDEX'(get_index(mem_address, S_INDEX));
  assign word   = get_word(mem_address);
  assign unused = ^mem_address[1:0];

  logic              data_we, tag_we, valid_we, valid_in, dirty_we, dirty_in;
  logic [LINE_W-1:0] data_in, line_data, merged;
  logic [TAG_W-1:0]  line_tag;
  logic              line_valid, line_dirty;

  cache_line_array #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_lines (
    .clk       (clk),
    .reset_n   (reset_n),
    .index     (idx),
    .data_we   (data_we),
    .data_in   (data_in),
    .tag_we    (tag_we),
    .tag_in    (tag),
    .valid_we  (valid_we),
    .valid_in  (valid_in),
    .dirty_we  (dirty_we),
    .dirty_in  (dirty_in),
    .data_out  (line_data),
    .tag_out   (line_tag),
    .valid_out (line_valid),
    .dirty_out (line_dirty)
  );

  logic req, hit;
  assign req = mem_read | mem_write;
  assign hit = line_valid && (line_tag == tag);

  // Store path: overlay the enabled bytes onto the selected word of the line.
  always_comb begin
    merged = line_data;
    for (int k = 0; k < 4; k++)
      if (mem_byte_en[k])
        merged[int'(word) * WORD_W + 8 * k +: 8] = mem_wdata[8 * k +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Load data is captured on the lookup edge so that it is stable during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mem_rdata <= '0;
    else if (state == IDLE && mem_read && hit)
      mem_rdata <= line_data[int'(word) * WORD_W +: WORD_W];
  end

  always_comb begin
    state_n  = state;
    data_we  = 1'b0;
    data_in  = merged;
    tag_we   = 1'b0;
    valid_we = 1'b0;
    valid_in = 1'b0;
    dirty_we = 1'b0;
    dirty_in = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        if (hit) begin
          state_n = RESP;
          if (mem_write) begin
            data_we  = 1'b1;
            dirty_we = 1'b1;
            dirty_in = 1'b1;
          end
        end else if (line_valid && line_dirty) begin
          state_n = WB;
        end else begin
          state_n = FILL;
        end
      end
      RESP: state_n = IDLE;
      WB: if (pmem_resp) begin
        dirty_we = 1'b1;
        state_n  = FILL;
      end
      FILL: if (pmem_resp) begin
        data_we  = 1'b1;
        data_in  = pmem_rdata;
        tag_we   = 1'b1;
        valid_we = 1'b1;
        valid_in = 1'b1;
        dirty_we = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode from the state register alone. Because that register has
  // an asynchronous reset, the outputs drop as soon as reset is asserted.
  always_comb begin
    mem_resp     = (state == RESP);
    pmem_read    = (state == FILL);
    pmem_write   = (state == WB);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state == WB) begin
      pmem_address = {line_tag, idx, 5'b0};
      pmem_wdata   = line_data;
    end else if (state == FILL) begin
      pmem_address = {tag, idx, 5'b0};
    end
  end
endmodule

// File: tb/tb_cache_dm_wb.sv
module tb_cache_dm_wb;
  localparam int S_INDEX = 4;
  localparam int NLINES  = 1 << S_INDEX;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
  logic         mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [3:0]   mem_byte_en;
  logic [255:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  cache_dm_wb #(.S_INDEX(S_INDEX)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory as the adaptor holds it. The CPU-visible memory is the reference
  // view: the last value stored to each word, or the backing value otherwise.
  logic [31:0] bmem[int];
  logic [31:0] ref_mem[int];

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] aa;
    aa = a;
    return (aa * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] bm_rd(input int a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : bm_rd(a);
  endfunction

  // Model of a direct-mapped cache: which line each set holds, plus its
  // valid and dirty bits.
  int res_line[NLINES];
  bit m_vld[NLINES];
  bit m_drt[NLINES];

  typedef struct { bit wr; logic [31:0] addr; } pm_t;
  typedef struct { bit rd; logic [31:0] data; } rs_t;
  pm_t pm_q[$];
  rs_t resp_q[$];

  int dly_min = 0;
  int dly_max = 20;

  // Adaptor model: it accepts one line request, waits a random delay, then
  // pulses pmem_resp. At the start of each request it checks the request
  // against the next expected line operation.
  initial begin
    int cnt;
    pm_t e;
    logic [31:0] a0;
    logic [255:0] ln;
    cnt = -1;
    a0 = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!reset_n) cnt = -1;
      else if (pmem_read || pmem_write) begin
        if (cnt < 0) begin
          a0 = pmem_address;
          check("pmem_exclusive", 256'(pmem_read && pmem_write), 256'(0));
          if (pm_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL pmem_unexpected: got %s at %h expected none",
                     pmem_write ? "write" : "read", pmem_address);
          end else begin
            e = pm_q.pop_front();
            check("pmem_dir", 256'(pmem_write), 256'(e.wr));
            check("pmem_addr", 256'(pmem_address), 256'(e.addr));
          end
          cnt = int'($urandom_range(dly_max, dly_min));
        end
        if (cnt == 0) begin
          check("pmem_hold", 256'(pmem_address), 256'(a0));
          if (pmem_write) begin
            for (int w = 0; w < 8; w++) ln[32*w +: 32] = ref_rd(int'(a0) + 4*w);
            check("wb_data", pmem_wdata, ln);
            for (int w = 0; w < 8; w++) bmem[int'(a0) + 4*w] = pmem_wdata[32*w +: 32];
          end else begin
            for (int w = 0; w < 8; w++) ln[32*w +: 32] = bm_rd(int'(a0) + 4*w);
            pmem_rdata = ln;
          end
          pmem_resp = 1'b1;
          cnt = -1;
        end else cnt--;
      end else cnt = -1;
    end
  end

  // Monitor: each mem_resp pulse consumes one expected response.
  initial begin
    rs_t r;
    forever begin
      @(negedge clk);
      if (reset_n && mem_resp) begin
        if (resp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_resp_unexpected: got resp for %h expected none", mem_address);
        end else begin
          r = resp_q.pop_front();
          if (r.rd) check("rdata", 256'(mem_rdata), 256'(r.data));
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int ln, idx, wa, cyc;
    bit hit;
    logic [31:0] nw;
    ln  = int'(addr >> 5);
    idx = ln % NLINES;
    wa  = int'(addr & 32'hFFFF_FFFC);
    hit = m_vld[idx] && res_line[idx] == ln;
    if (!hit) begin
      if (m_vld[idx] && m_drt[idx]) pm_q.push_back('{wr: 1'b1, addr: 32'(res_line[idx] << 5)});
      pm_q.push_back('{wr: 1'b0, addr: addr & 32'hFFFF_FFE0});
      res_line[idx] = ln;
      m_vld[idx] = 1'b1;
      m_drt[idx] = 1'b0;
    end
    if (wr) begin
      m_drt[idx] = 1'b1;
      nw = ref_rd(wa);
      for (int k = 0; k < 4; k++) if (be[k]) nw[8*k +: 8] = wd[8*k +: 8];
      ref_mem[wa] = nw;
      resp_q.push_back('{rd: 1'b0, data: 32'h0});
    end else begin
      resp_q.push_back('{rd: 1'b1, data: ref_rd(wa)});
    end
    mem_address = addr;
    mem_byte_en = wr ? be : 4'h0;
    mem_wdata   = wd;
    mem_read    = !wr;
    mem_write   = wr;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 3000);
    if (!mem_resp) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: got no mem_resp for %h expected one within 3000 cycles", addr);
      resp_q.delete();
      pm_q.delete();
    end else if (hit) begin
      check("hit_latency", 256'(cyc), 256'(1));
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("pmem_ops_done", 256'(pm_q.size()), 256'(0));
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_en = '0; mem_wdata = '0;
    for (int i = 0; i < NLINES; i++) begin m_vld[i] = 0; m_drt[i] = 0; res_line[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_mem_resp",  256'(mem_resp),     256'(0));
    check("rst_pmem_read", 256'(pmem_read),    256'(0));
    check("rst_pmem_write",256'(pmem_write),   256'(0));
    check("rst_mem_rdata", 256'(mem_rdata),    256'(0));
    check("rst_pmem_addr", 256'(pmem_address), 256'(0));
    check("rst_pmem_wdata",pmem_wdata,         256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // cold read, repeat hit, partial store, then a read that sees the merge
    bmem['h40] = 32'hDEAD_BEEF;
    bmem['h44] = 32'hDEAD_BEEF;
    do_req(0, 32'h40, 4'h0, 32'h0);
    do_req(0, 32'h44, 4'h0, 32'h0);
    do_req(1, 32'h44, 4'b0011, 32'h1234_5678);
    do_req(0, 32'h44, 4'h0, 32'h0);
    // conflict on the same index: the dirty victim is written back, then the new line is filled
    do_req(0, 32'h240, 4'h0, 32'h0);

    // reset during a fill
    dly_min = 200; dly_max = 200;
    pm_q.push_back('{wr: 1'b0, addr: 32'h40});
    mem_address = 32'h40; mem_read = 1'b1;
    cyc = 0;
    while (!pmem_read && cyc < 20) begin @(negedge clk); cyc++; end
    check("fill_started", 256'(pmem_read), 256'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_mid_mem_resp",  256'(mem_resp),  256'(0));
    check("rst_mid_pmem_addr", 256'(pmem_address), 256'(0));
    mem_read = 1'b0;
    for (int i = 0; i < NLINES; i++) begin m_vld[i] = 0; m_drt[i] = 0; end
    ref_mem.delete();
    resp_q.delete();
    pm_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dly_min = 0; dly_max = 20;
    @(negedge clk);
    do_req(0, 32'h40, 4'h0, 32'h0);

    // touch every set (store to even sets, load from odd), then sweep conflicting lines
    for (int i = 0; i < NLINES; i++) begin
      logic [31:0] a;
      a = 32'h1000 + 32'(i * 32) + 32'(4 * $urandom_range(7, 0));
      if (i % 2 == 0) do_req(1, a, 4'($urandom), $urandom);
      else            do_req(0, a, 4'h0, 32'h0);
    end
    for (int i = 0; i < NLINES; i++)
      do_req(0, 32'h3000 + 32'(i * 32), 4'h0, 32'h0);

    // random traffic over 64 lines, so that conflicts occur often
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(32'h7FF, 0));
      do_req(bit'($urandom % 2), a, 4'($urandom), $urandom);
    end

    check("resp_q_drained", 256'(resp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
